// File: rtl/panel_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | panel_pkg                                                                |
// | Shared display-mode and bounce-direction encodings for the LED sequencer.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package panel_pkg;

    typedef enum logic [1:0] {
        LED_CHASE  = 2'd0,
        LED_BOUNCE = 2'd1,
        LED_FILL   = 2'd2,
        LED_HOLD   = 2'd3
    } led_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage
`default_nettype wire

// File: rtl/led_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_prescaler                                                            |
// | Programmable step-rate divider; tick pulses once every 'period' clocks.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module led_prescaler #(
    parameter int PERIOD_W = 26
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] r_cnt;
    logic                w_hit;

    // Periods 0 and 1 both collapse to a tick every clock; this also avoids period-1 underflow.
    assign w_hit = (period <= PERIOD_W'(1)) || (r_cnt >= (period - PERIOD_W'(1)));
    assign tick  = enable & w_hit;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (!enable || clear || w_hit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PERIOD_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/panel_led_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | panel_led_sequencer                                                      |
// | Front-panel LED pattern generator: chase, bounce, fill and hold modes.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module panel_led_sequencer
    import panel_pkg::*;
#(
    parameter int NUM_LEDS = 44,
    parameter int PERIOD_W = 26
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                step,
    input  logic                load,
    input  logic [NUM_LEDS-1:0] load_pattern,
    output logic [NUM_LEDS-1:0] leds,
    output logic                wrap
);

    localparam logic [NUM_LEDS-1:0] c_LED_ONE = NUM_LEDS'(1);

    led_mode_t           w_mode;
    led_mode_t           r_mode;
    logic                w_change;
    logic                w_tick;
    logic                w_adv;
    logic [NUM_LEDS-1:0] r_leds;
    logic [NUM_LEDS-1:0] w_leds_nxt;
    logic [NUM_LEDS-1:0] w_shift;
    logic                r_dir;
    logic                w_dir_nxt;
    logic                r_wrap;
    logic                w_wrap_nxt;

    assign w_mode   = led_mode_t'(mode);
    assign w_change = (w_mode != r_mode);
    assign w_adv    = w_tick | step;

    led_prescaler #(
        .PERIOD_W (PERIOD_W)
    ) u_prescaler (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (w_change),
        .period  (period),
        .tick    (w_tick)
    );

    always_comb begin
        w_leds_nxt = r_leds;
        w_dir_nxt  = r_dir;
        w_wrap_nxt = 1'b0;
        w_shift    = '0;
        if (w_change) begin
            case (w_mode)
                LED_CHASE:  w_leds_nxt = c_LED_ONE;
                LED_BOUNCE: begin
                    w_leds_nxt = c_LED_ONE;
                    w_dir_nxt  = DIR_UP;
                end
                LED_FILL:   w_leds_nxt = '0;
                default:    w_leds_nxt = r_leds;
            endcase
        end else if (load) begin
            w_leds_nxt = load_pattern;
        end else if (w_adv) begin
            case (r_mode)
                LED_CHASE: begin
                    w_leds_nxt = (r_leds == '0) ? c_LED_ONE
                                                : {r_leds[NUM_LEDS-2:0], r_leds[NUM_LEDS-1]};
                    w_wrap_nxt = r_leds[NUM_LEDS-1];
                end
                LED_BOUNCE: begin
                    w_shift = (r_dir == DIR_UP) ? (r_leds << 1) : (r_leds >> 1);
                    // An empty result (e.g. after loading zero) restarts the sweep from bit 0.
                    if (w_shift == '0) begin
                        w_leds_nxt = c_LED_ONE;
                        w_dir_nxt  = DIR_UP;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_leds_nxt = w_shift;
                        if (r_dir == DIR_UP && w_shift[NUM_LEDS-1]) begin
                            w_dir_nxt = DIR_DOWN;
                        end else if (r_dir == DIR_DOWN && w_shift[0]) begin
                            w_dir_nxt  = DIR_UP;
                            w_wrap_nxt = 1'b1;
                        end
                    end
                end
                LED_FILL: begin
                    if (&r_leds) begin
                        w_leds_nxt = '0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_leds_nxt = {r_leds[NUM_LEDS-2:0], 1'b1};
                    end
                end
                default: w_leds_nxt = r_leds;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= LED_CHASE;
            r_leds <= c_LED_ONE;
            r_dir  <= DIR_UP;
            r_wrap <= 1'b0;
        end else begin
            r_mode <= w_mode;
            r_leds <= w_leds_nxt;
            r_dir  <= w_dir_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign leds = r_leds;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_panel_led_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_panel_led_sequencer                                                   |
// | Scoreboard bench for the LED sequencer with an 8-LED panel.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_panel_led_sequencer;

    localparam int N  = 8;
    localparam int PW = 8;

    typedef struct {
        string      name;
        logic [7:0] leds;
        logic       wrap;
    } exp_t;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b1;
    logic          enable  = 1'b0;
    logic [1:0]    mode    = 2'd0;
    logic [PW-1:0] period  = '0;
    logic          step    = 1'b0;
    logic          load    = 1'b0;
    logic [N-1:0]  load_pattern = '0;
    logic [N-1:0]  leds;
    logic          wrap;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    panel_led_sequencer #(
        .NUM_LEDS (N),
        .PERIOD_W (PW)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .enable       (enable),
        .mode         (mode),
        .period       (period),
        .step         (step),
        .load         (load),
        .load_pattern (load_pattern),
        .leds         (leds),
        .wrap         (wrap)
    );

    always #5 clk_sys = ~clk_sys;

    // Monitor: every registered output is compared just after the edge that produced it.
    always begin
        @(posedge clk_sys);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (leds !== e.leds || wrap !== e.wrap) begin
                errors++;
                $display("FAIL %s: got leds=%h wrap=%b, expected leds=%h wrap=%b",
                         e.name, leds, wrap, e.leds, e.wrap);
            end
        end
    end

    task automatic cyc(input string name, input logic [7:0] el, input logic ew);
        exp_t e;
        e.name = name;
        e.leds = el;
        e.wrap = ew;
        q.push_back(e);
        @(negedge clk_sys);
    endtask

    task automatic direct(input string name, input logic [7:0] el, input logic ew);
        checks++;
        if (leds !== el || wrap !== ew) begin
            errors++;
            $display("FAIL %s: got leds=%h wrap=%b, expected leds=%h wrap=%b",
                     name, leds, wrap, el, ew);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cur;
        logic [7:0] nxt;

        // Asynchronous reset before any clock edge
        #3 reset_n = 1'b0;
        #1 direct("reset_async", 8'h01, 1'b0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // CHASE, period 3: a step on every third clock, wrap only on 80->01
        enable = 1'b1;
        period = 8'd3;
        cur    = 8'h01;
        for (int s = 0; s < 8; s++) begin
            cyc("chase_hold1", cur, 1'b0);
            cyc("chase_hold2", cur, 1'b0);
            nxt = {cur[6:0], cur[7]};
            cyc("chase_step", nxt, cur[7]);
            cur = nxt;
        end

        // BOUNCE via manual steps with the prescaler off
        enable = 1'b0;
        mode   = 2'd1;
        cyc("bounce_entry", 8'h01, 1'b0);
        step = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            nxt = (i <= 7) ? (8'h01 << i) : (8'h80 >> (i - 7));
            cyc("bounce_step", nxt, (i == 14));
        end
        step = 1'b0;

        // FILL at period 1: 9-clock cycle with wrap on FF->00
        mode   = 2'd2;
        enable = 1'b1;
        period = 8'd1;
        cyc("fill_entry", 8'h00, 1'b0);
        cur = 8'h00;
        for (int i = 0; i < 18; i++) begin
            if (cur == 8'hFF) begin
                cyc("fill_wrap", 8'h00, 1'b1);
                cur = 8'h00;
            end else begin
                nxt = {cur[6:0], 1'b1};
                cyc("fill_step", nxt, 1'b0);
                cur = nxt;
            end
        end

        // Priority: load beats step; mode change beats load
        enable = 1'b0;
        mode   = 2'd0;
        cyc("prio_chase_entry", 8'h01, 1'b0);
        load         = 1'b1;
        load_pattern = 8'hA5;
        step         = 1'b1;
        cyc("prio_load_over_step", 8'hA5, 1'b0);
        step = 1'b0;
        mode = 2'd2;
        cyc("prio_mode_over_load", 8'h00, 1'b0);
        load = 1'b0;

        // CHASE zero recovery
        mode = 2'd0;
        cyc("zero_chase_entry", 8'h01, 1'b0);
        load         = 1'b1;
        load_pattern = 8'h00;
        cyc("zero_load", 8'h00, 1'b0);
        load = 1'b0;
        step = 1'b1;
        cyc("zero_recover", 8'h01, 1'b0);
        step = 1'b0;

        // HOLD ignores ticks
        mode = 2'd3;
        cyc("hold_entry", 8'h01, 1'b0);
        load         = 1'b1;
        load_pattern = 8'h3C;
        cyc("hold_load", 8'h3C, 1'b0);
        load   = 1'b0;
        enable = 1'b1;
        period = 8'd1;
        for (int i = 0; i < 10; i++) begin
            cyc("hold_tick", 8'h3C, 1'b0);
        end

        // Reset in the middle of a running chase
        mode = 2'd0;
        cyc("mid_chase_entry", 8'h01, 1'b0);
        cyc("mid_chase_1", 8'h02, 1'b0);
        cyc("mid_chase_2", 8'h04, 1'b0);
        cyc("mid_chase_3", 8'h08, 1'b0);
        #2 reset_n = 1'b0;
        #1 direct("reset_mid_op", 8'h01, 1'b0);
        @(negedge clk_sys);
        direct("reset_held", 8'h01, 1'b0);
        reset_n = 1'b1;
        enable  = 1'b0;
        @(negedge clk_sys);
        @(negedge clk_sys);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
